// File: rtl/delay_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// delay_pipeline_pkg
//   Shared helpers for the delay_pipeline block.
//   - count_width(cycles): width of the occupancy counter, max(1, clog2(cycles+1)).
//   The {valid, data} stage record is declared inside the modules, because its
//   width follows the WIDTH parameter of the instantiating module.
// ---------------------------------------------------------------------------
package delay_pipeline_pkg;

    function automatic int count_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// ---------------------------------------------------------------------------
// delay_stage
//   One enabled, flushable {valid, data} register of the delay pipeline.
//   Optional build macro: DELAY_PIPELINE_RESET_DATA_EN (data register joins the
//   asynchronous reset and loads INIT_VALUE).
//
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset (valid bit always, data only
//                   with the macro defined)
//     en_i     in   advance enable; 0 = hold valid and data
//     flush_i  in   synchronous clear of the valid bit, independent of en_i
//     stage_i  in   {valid, data} from the previous stage
//     stage_o  out  {valid, data} held by this stage
// ---------------------------------------------------------------------------
module delay_stage #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           flush_i,
    input  logic [WIDTH:0] stage_i,
    output logic [WIDTH:0] stage_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Flush wins over a simultaneous enabled load, so a valid input arriving
    // with flush is dropped.
    always_comb begin
        vld_d = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (en_i) begin
            vld_d = stage_i[WIDTH];
        end
    end

    // Data moves with en_i regardless of valid or flush.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = stage_i[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

`ifdef DELAY_PIPELINE_RESET_DATA_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= INIT_VALUE;
        end else begin
            data_q <= data_d;
        end
    end
`else
    // No reset on data so the chain can map onto plain shift-register cells.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    logic [WIDTH-1:0] unused_init;
    assign unused_init = INIT_VALUE;
`endif

    assign stage_o = {vld_q, data_q};

endmodule

// File: rtl/delay_pipeline.sv
// ---------------------------------------------------------------------------
// delay_pipeline
//   CYCLES-deep chain of WIDTH-bit enabled registers, each with a valid bit,
//   plus a synchronous flush and a live count of stages holding valid data.
//   CYCLES = 0 degenerates to a combinational pass-through with no state.
//   Optional build macro: DELAY_PIPELINE_RESET_DATA_EN (data registers reset
//   to INIT_VALUE; otherwise data registers are not reset).
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     en         in   advance enable; 0 = every stage and count hold
//     flush      in   synchronous clear of all valid bits and count
//     valid_in   in   qualifies in
//     in         in   data input (WIDTH)
//     valid_out  out  valid bit of the last stage
//     out        out  data of the last stage (WIDTH)
//     count      out  number of stages holding valid data
// ---------------------------------------------------------------------------
module delay_pipeline
    import delay_pipeline_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               CYCLES     = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             flush,
    input  logic                             valid_in,
    input  logic [WIDTH-1:0]                 in,
    output logic                             valid_out,
    output logic [WIDTH-1:0]                 out,
    output logic [count_width(CYCLES)-1:0]   count
);

    localparam int CW = count_width(CYCLES);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } stage_t;

    if (CYCLES == 0) begin : g_pass

        assign out       = in;
        assign valid_out = valid_in;
        assign count     = '0;

        logic unused_ok;
        assign unused_ok = ^{clk, rst, en, flush, INIT_VALUE};

    end else begin : g_pipe

        // stg[0] is the input record; stg[i+1] is the output of stage i.
        stage_t stg [CYCLES+1];

        assign stg[0] = '{vld: valid_in, data: in};

        for (genvar i = 0; i < CYCLES; i++) begin : g_stage
            delay_stage #(
                .WIDTH      (WIDTH),
                .INIT_VALUE (INIT_VALUE)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (en),
                .flush_i (flush),
                .stage_i (stg[i]),
                .stage_o (stg[i+1])
            );
        end

        logic [CW-1:0] count_q, count_d;

        // One in and one out on the same enabled edge nets to zero; the
        // subtraction uses the pre-edge valid_out, i.e. the record leaving.
        always_comb begin
            count_d = count_q;
            if (flush) begin
                count_d = '0;
            end else if (en) begin
                count_d = count_q + CW'(valid_in) - CW'(stg[CYCLES].vld);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign count     = count_q;
        assign valid_out = stg[CYCLES].vld;
        assign out       = stg[CYCLES].data;

`ifndef SYNTHESIS
        localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

        logic [CYCLES-1:0] vld_vec;
        always_comb begin
            vld_vec = '0;
            for (int k = 0; k < CYCLES; k++) begin
                vld_vec[k] = stg[k+1].vld;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                assert (count_q <= CNT_MAX)
                    else $error("delay_pipeline: count %0d above depth", count_q);
                assert (count_q == CW'($countones(vld_vec)))
                    else $error("delay_pipeline: count %0d != valid popcount", count_q);
            end
        end
`endif

    end

endmodule

// File: tb/tb_delay_pipeline.sv
module tb_delay_pipeline;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] din = 8'h00;

    logic       vo4, vo1, vo0;
    logic [7:0] o4, o1, o0;
    logic [2:0] c4;
    logic [0:0] c1, c0;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    delay_pipeline #(.WIDTH(8), .CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .in(din), .valid_out(vo4), .out(o4), .count(c4));

    delay_pipeline #(.WIDTH(8), .CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .in(din), .valid_out(vo1), .out(o1), .count(c1));

    delay_pipeline #(.WIDTH(8), .CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .in(din), .valid_out(vo0), .out(o0), .count(c0));

    // Reference: each pipeline is a fixed-length queue of {valid, data}
    // records; front = newest, back = what the output shows.
    logic [8:0] q4[$];
    logic [8:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (q4[i]) q4[i][8] = 1'b0;
        foreach (q1[i]) q1[i][8] = 1'b0;
`ifdef DELAY_PIPELINE_RESET_DATA_EN
        foreach (q4[i]) q4[i] = 9'h000;
        foreach (q1[i]) q1[i] = 9'h000;
`endif
    endtask

    task automatic model_edge();
        if (rst) return;
        if (en) begin
            q4.push_front({valid_in, din});
            void'(q4.pop_back());
            q1.push_front({valid_in, din});
            void'(q1.pop_back());
        end
        if (flush) begin
            foreach (q4[i]) q4[i][8] = 1'b0;
            foreach (q1[i]) q1[i][8] = 1'b0;
        end
    endtask

    function automatic int occ4();
        int c = 0;
        foreach (q4[i]) c += int'(q4[i][8]);
        return c;
    endfunction

    function automatic int occ1();
        int c = 0;
        foreach (q1[i]) c += int'(q1[i][8]);
        return c;
    endfunction

    task automatic check_d4_model();
        logic [8:0] t;
        t = q4[q4.size()-1];
        chk("d4_valid", 32'(vo4), 32'(t[8]));
        chk("d4_count", 32'(c4), 32'(occ4()));
        if (t[8]) chk("d4_out", 32'(o4), 32'(t[7:0]));
    endtask

    task automatic check_d1_model();
        logic [8:0] t;
        t = q1[0];
        chk("d1_valid", 32'(vo1), 32'(t[8]));
        chk("d1_count", 32'(c1), 32'(occ1()));
        if (t[8]) chk("d1_out", 32'(o1), 32'(t[7:0]));
    endtask

    // One clock of stimulus: drive at negedge, check the pass-through before
    // the edge, advance the model at the edge, check registered DUTs after it.
    task automatic apply(input logic e, input logic f, input logic v, input logic [7:0] d);
        @(negedge clk);
        en = e; flush = f; valid_in = v; din = d;
        #1;
        chk("d0_valid", 32'(vo0), 32'(v));
        if (v) chk("d0_out", 32'(o0), 32'(d));
        chk("d0_count", 32'(c0), 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        check_d1_model();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        en = 1'b0; flush = 1'b0; valid_in = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_d4_valid", 32'(vo4), 32'd0);
        chk("rst_d4_count", 32'(c4), 32'd0);
        chk("rst_d1_valid", 32'(vo1), 32'd0);
        chk("rst_d1_count", 32'(c1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       e, f, v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] eo;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic f, input logic v, input logic [7:0] d,
                       input logic ev, input logic [7:0] eo, input int ec);
        vec_t r;
        r.e = e; r.f = f; r.v = v; r.d = d; r.ev = ev; r.eo = eo; r.ec = ec;
        tbl.push_back(r);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) q4.push_back(9'h000);
        q1.push_back(9'h000);

        // Expected depth-4 outputs after the edge that samples each row.
        //   en flush vin din    vout out   count
        add(1, 0, 1, 8'h01,  0, 8'h00, 1);   // streaming ramp
        add(1, 0, 1, 8'h02,  0, 8'h00, 2);
        add(1, 0, 1, 8'h03,  0, 8'h00, 3);
        add(1, 0, 1, 8'h04,  1, 8'h01, 4);
        add(1, 0, 1, 8'h05,  1, 8'h02, 4);
        add(0, 0, 1, 8'hFF,  1, 8'h02, 4);   // stall, FF must not enter
        add(0, 0, 1, 8'hFF,  1, 8'h02, 4);
        add(0, 0, 1, 8'hFF,  1, 8'h02, 4);
        add(1, 0, 1, 8'h06,  1, 8'h03, 4);
        add(1, 0, 1, 8'h07,  1, 8'h04, 4);
        add(1, 0, 1, 8'h08,  1, 8'h05, 4);
        add(1, 0, 1, 8'h09,  1, 8'h06, 4);
        add(1, 1, 1, 8'hAA,  0, 8'h00, 0);   // flush beats valid_in
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);
        add(1, 0, 1, 8'h11,  0, 8'h00, 1);   // bubbles 1,0,1,1,0
        add(1, 0, 0, 8'h12,  0, 8'h00, 1);
        add(1, 0, 1, 8'h13,  0, 8'h00, 2);
        add(1, 0, 1, 8'h14,  1, 8'h11, 3);
        add(1, 0, 0, 8'h15,  0, 8'h00, 2);
        add(1, 0, 0, 8'h00,  1, 8'h13, 2);
        add(1, 0, 0, 8'h00,  1, 8'h14, 1);
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);
        add(1, 0, 1, 8'h21,  0, 8'h00, 1);   // flush while stalled
        add(0, 1, 1, 8'h22,  0, 8'h00, 0);
        add(1, 0, 0, 8'h00,  0, 8'h00, 0);

        // Reset held for 5 cycles
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("reset_d4_valid", 32'(vo4), 32'd0);
            chk("reset_d4_count", 32'(c4), 32'd0);
            chk("reset_d1_valid", 32'(vo1), 32'd0);
            chk("reset_d1_count", 32'(c1), 32'd0);
`ifdef DELAY_PIPELINE_RESET_DATA_EN
            chk("reset_d4_out", 32'(o4), 32'h00);
            chk("reset_d1_out", 32'(o1), 32'h00);
`endif
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven scenarios
        foreach (tbl[i]) begin
            apply(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), 32'(vo4), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 32'(c4), 32'(tbl[i].ec));
            if (tbl[i].ev) chk($sformatf("tbl%0d_out", i), 32'(o4), 32'(tbl[i].eo));
            check_d4_model();
        end

        // Reset mid-stream: in-flight data lost, first new valid after 4 edges
        apply(1, 0, 1, 8'h31);
        apply(1, 0, 1, 8'h32);
        chk("mid_pre_count", 32'(c4), 32'd2);
        pulse_reset();
        apply(1, 0, 1, 8'h41);
        chk("mid_e1_valid", 32'(vo4), 32'd0);
        apply(1, 0, 1, 8'h42);
        chk("mid_e2_valid", 32'(vo4), 32'd0);
        apply(1, 0, 1, 8'h43);
        chk("mid_e3_valid", 32'(vo4), 32'd0);
        apply(1, 0, 1, 8'h44);
        chk("mid_e4_valid", 32'(vo4), 32'd1);
        chk("mid_e4_out", 32'(o4), 32'h41);
        chk("mid_e4_count", 32'(c4), 32'd4);

        // Randomized stimulus against the queue model
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                pulse_reset();
            end else begin
                apply(($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 4) < 3),
                      8'($urandom));
                check_d4_model();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
